// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The metadata queue and the instruction buffer carry these records.
package fetch_pkg;

    localparam int FETCH_W = 32;
    localparam logic [FETCH_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [FETCH_W-1:0] pc;
        logic [FETCH_W-1:0] pc_plus4;
    } fetch_meta_t;

    typedef struct packed {
        logic [FETCH_W-1:0] instr;
        logic [FETCH_W-1:0] pc;
        logic [FETCH_W-1:0] pc_plus4;
        logic               fault;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small typed FIFO with a show-ahead head and a synchronous clear.
// The clear wins over a push or pop in the same cycle.
module sync_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  T                           push_data,
    input  logic                       pop,
    output T                           pop_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CW'(DEPTH));
    assign count    = count_reg;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr_reg];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage has no reset; stale words are never visible because empty gates the head.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr_reg] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: credit-limited in-order requests to a variable-latency
// instruction memory, response buffering toward decode, and redirect squashing.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int IBUF_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_i,
    input  logic [WIDTH-1:0] pc_plus4_i,
    output logic             pc_en_o,
    input  logic             redirect_i,
    output logic             imem_req_valid_o,
    input  logic             imem_req_ready_i,
    output logic [WIDTH-1:0] imem_addr_o,
    input  logic             imem_rsp_valid_i,
    input  logic [WIDTH-1:0] imem_rsp_data_i,
    input  logic             imem_rsp_err_i,
    output logic             id_valid_o,
    input  logic             id_ready_i,
    output logic [WIDTH-1:0] id_instr_o,
    output logic [WIDTH-1:0] id_pc_o,
    output logic [WIDTH-1:0] id_pc_plus4_o,
    output logic             id_fault_o
);

    localparam int CW = $clog2(IBUF_DEPTH + 1);

    logic [CW-1:0] inflight_reg, inflight_next;
    logic [CW-1:0] drop_cnt_reg, drop_cnt_next;
    logic [CW-1:0] ibuf_count, meta_count;
    logic [CW:0]   credit_used;
    logic          ibuf_empty, ibuf_full, meta_empty, meta_full;
    logic          req_accept, rsp_keep, ibuf_pop;
    fetch_meta_t   meta_in, meta_head;
    fetch_entry_t  ibuf_in, ibuf_head;

    // Requests in flight (including ones doomed to be dropped) plus buffered entries share one credit pool.
    assign credit_used      = {1'b0, inflight_reg} + {1'b0, ibuf_count};
    assign imem_req_valid_o = rst && !redirect_i && (credit_used < (CW+1)'(IBUF_DEPTH));
    assign req_accept       = imem_req_valid_o && imem_req_ready_i;
    assign pc_en_o          = req_accept;
    assign imem_addr_o      = pc_i;

    assign rsp_keep = imem_rsp_valid_i && !redirect_i && (drop_cnt_reg == '0);
    assign meta_in  = '{pc: pc_i, pc_plus4: pc_plus4_i};
    assign ibuf_in  = '{instr: imem_rsp_data_i, pc: meta_head.pc,
                        pc_plus4: meta_head.pc_plus4, fault: imem_rsp_err_i};

    assign id_valid_o    = !ibuf_empty && !redirect_i;
    assign ibuf_pop      = id_valid_o && id_ready_i;
    assign id_instr_o    = id_valid_o ? ibuf_head.instr : NOP_INSTR;
    assign id_pc_o       = id_valid_o ? ibuf_head.pc : '0;
    assign id_pc_plus4_o = id_valid_o ? ibuf_head.pc_plus4 : '0;
    assign id_fault_o    = id_valid_o && ibuf_head.fault;

    always_comb begin
        inflight_next = inflight_reg;
        case ({req_accept, imem_rsp_valid_i})
            2'b10:   inflight_next = inflight_reg + 1'b1;
            2'b01:   inflight_next = inflight_reg - 1'b1;
            default: inflight_next = inflight_reg;
        endcase

        drop_cnt_next = drop_cnt_reg;
        if (redirect_i)
            drop_cnt_next = inflight_reg - CW'(imem_rsp_valid_i);
        else if (imem_rsp_valid_i && (drop_cnt_reg != '0))
            drop_cnt_next = drop_cnt_reg - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_reg <= '0;
            drop_cnt_reg <= '0;
        end else begin
            inflight_reg <= inflight_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    sync_fifo #(.T(fetch_meta_t), .DEPTH(IBUF_DEPTH)) u_meta_q (
        .clk       (clk),
        .rst       (rst),
        .clr       (redirect_i),
        .push      (req_accept),
        .push_data (meta_in),
        .pop       (rsp_keep),
        .pop_data  (meta_head),
        .empty     (meta_empty),
        .full      (meta_full),
        .count     (meta_count)
    );

    sync_fifo #(.T(fetch_entry_t), .DEPTH(IBUF_DEPTH)) u_ibuf (
        .clk       (clk),
        .rst       (rst),
        .clr       (redirect_i),
        .push      (rsp_keep),
        .push_data (ibuf_in),
        .pop       (ibuf_pop),
        .pop_data  (ibuf_head),
        .empty     (ibuf_empty),
        .full      (ibuf_full),
        .count     (ibuf_count)
    );

    // Every surviving in-flight request owns exactly one metadata record.
    a_ibuf_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(rsp_keep && ibuf_full));
    a_meta_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(req_accept && meta_full));
    a_meta_present:     assert property (@(posedge clk) disable iff (!rst) !(rsp_keep && meta_empty));
    a_meta_tracks:      assert property (@(posedge clk) disable iff (!rst) meta_count == inflight_reg - drop_cnt_reg);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model with programmable latency,
// decode scoreboard, and a cycle-level credit model derived from the fetch rules.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int          WIDTH  = 32;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] NO_ERR = 32'hFFFF_FFFC;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] pc_i = '0;
    logic [WIDTH-1:0] pc_plus4_i = 32'd4;
    logic             pc_en_o;
    logic             redirect_i = 1'b0;
    logic             imem_req_valid_o;
    logic             imem_req_ready_i = 1'b0;
    logic [WIDTH-1:0] imem_addr_o;
    logic             imem_rsp_valid_i = 1'b0;
    logic [WIDTH-1:0] imem_rsp_data_i = '0;
    logic             imem_rsp_err_i = 1'b0;
    logic             id_valid_o;
    logic             id_ready_i = 1'b0;
    logic [WIDTH-1:0] id_instr_o;
    logic [WIDTH-1:0] id_pc_o;
    logic [WIDTH-1:0] id_pc_plus4_o;
    logic             id_fault_o;

    always #5 clk = ~clk;

    fetch_unit #(.WIDTH(WIDTH), .IBUF_DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .pc_i             (pc_i),
        .pc_plus4_i       (pc_plus4_i),
        .pc_en_o          (pc_en_o),
        .redirect_i       (redirect_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_addr_o      (imem_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .imem_rsp_err_i   (imem_rsp_err_i),
        .id_valid_o       (id_valid_o),
        .id_ready_i       (id_ready_i),
        .id_instr_o       (id_instr_o),
        .id_pc_o          (id_pc_o),
        .id_pc_plus4_o    (id_pc_plus4_o),
        .id_fault_o       (id_fault_o)
    );

    typedef struct {
        logic [31:0] start_pc;
        int          limit;
        int          lat;
        int          redir_at;
        logic [31:0] redir_pc;
        logic [31:0] err_pc;
        bit          gap;
        int          exp_n;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t        mq[$];
    fetch_entry_t exp_q[$];
    vec_t         vecs[5];

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          inflight_m = 0, ibuf_m = 0, drop_m = 0;
    int          accepted = 0, delivered = 0, limit = 0, lat = 1;
    int          redir_cyc = -1;
    logic [31:0] redir_pc = '0;
    logic [31:0] err_pc = NO_ERR;
    bit          rdy_gap = 1'b0;
    bit          id_ready_en = 1'b1;

    function automatic logic [31:0] instr_of(logic [31:0] a);
        return {a[23:0], 8'h13};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: compare at negedge, apply the model, then drive next inputs after the edge.
    task automatic cycle();
        bit           acc;
        bit           dpop;
        bit           rv_exp;
        fetch_entry_t e;
        mreq_t        m;
        acc = 1'b0;
        @(negedge clk);
        if (rst) begin
            rv_exp = !redirect_i && (inflight_m + ibuf_m < DEPTH);
            check("req_valid", 32'(imem_req_valid_o), 32'(rv_exp));
            check("pc_en", 32'(pc_en_o), 32'(rv_exp && imem_req_ready_i));
            check("id_valid", 32'(id_valid_o), 32'((ibuf_m > 0) && !redirect_i));
            acc  = imem_req_valid_o && imem_req_ready_i;
            dpop = id_valid_o && id_ready_i;
            if (dpop) begin
                delivered++;
                ibuf_m--;
                $display("bundle pc=%h pc4=%h instr=%h fault=%0b", id_pc_o, id_pc_plus4_o, id_instr_o, id_fault_o);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_bundle: got pc %h expected none", id_pc_o);
                end else begin
                    e = exp_q.pop_front();
                    check("id_instr", id_instr_o, e.instr);
                    check("id_pc", id_pc_o, e.pc);
                    check("id_pc_plus4", id_pc_plus4_o, e.pc_plus4);
                    check("id_fault", 32'(id_fault_o), 32'(e.fault));
                end
            end
            if (acc) begin
                accepted++;
                inflight_m++;
                check("imem_addr", imem_addr_o, pc_i);
                mq.push_back('{addr: pc_i, due: cyc + lat});
                exp_q.push_back('{instr: instr_of(pc_i), pc: pc_i, pc_plus4: pc_plus4_i,
                                  fault: (pc_i == err_pc)});
            end
            if (imem_rsp_valid_i) begin
                inflight_m--;
                if (!redirect_i) begin
                    if (drop_m > 0) drop_m--;
                    else            ibuf_m++;
                end
            end
            if (redirect_i) begin
                drop_m = inflight_m;
                ibuf_m = 0;
                exp_q.delete();
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (acc) pc_i = pc_i + 32'd4;
        redirect_i = (cyc == redir_cyc);
        if (redirect_i) pc_i = redir_pc;
        pc_plus4_i       = pc_i + 32'd4;
        imem_req_ready_i = (accepted < limit);
        id_ready_i       = rdy_gap ? ((cyc % 3) != 0) : id_ready_en;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            m = mq.pop_front();
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = instr_of(m.addr);
            imem_rsp_err_i   = (m.addr == err_pc);
        end else begin
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = '0;
            imem_rsp_err_i   = 1'b0;
        end
    endtask

    task automatic start_stream(logic [31:0] spc, int lim, int l, int rat,
                                logic [31:0] rpc, logic [31:0] epc, bit gap);
        pc_i             = spc;
        pc_plus4_i       = spc + 32'd4;
        limit            = lim;
        lat              = l;
        redir_cyc        = (rat > 0) ? cyc + rat : -1;
        redir_pc         = rpc;
        err_pc           = epc;
        rdy_gap          = gap;
        accepted         = 0;
        delivered        = 0;
        imem_req_ready_i = 1'b1;
        id_ready_i       = gap ? ((cyc % 3) != 0) : id_ready_en;
    endtask

    task automatic drain(int exp_n);
        int guard;
        guard = 0;
        while ((accepted < limit || mq.size() > 0 || exp_q.size() > 0 || ibuf_m > 0) && guard < 400) begin
            cycle();
            guard++;
        end
        if (guard >= 400) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got accepted=%0d delivered=%0d expected limit=%0d", accepted, delivered, limit);
        end
        check("delivered", 32'(delivered), 32'(exp_n));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // start_pc, limit, lat, redir_at, redir_pc, err_pc, gap, exp_n
        vecs[0] = '{32'h0000_0000, 6, 1, 0, 32'h0,        NO_ERR,       1'b0, 6};
        vecs[1] = '{32'h0000_0200, 5, 3, 0, 32'h0,        NO_ERR,       1'b1, 5};
        vecs[2] = '{32'h0000_0010, 6, 4, 2, 32'h0000_0100, NO_ERR,      1'b0, 4};
        vecs[3] = '{32'h0000_0010, 5, 2, 2, 32'h0000_0300, NO_ERR,      1'b0, 3};
        vecs[4] = '{32'h0000_0018, 4, 2, 0, 32'h0,        32'h0000_0020, 1'b0, 4};

        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_id_valid", 32'(id_valid_o), 32'd0);
        check("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
        check("rst_pc_en", 32'(pc_en_o), 32'd0);
        check("rst_id_pc", id_pc_o, 32'd0);
        check("rst_id_fault", 32'(id_fault_o), 32'd0);
        rst         = 1'b1;
        id_ready_en = 1'b1;

        for (int i = 0; i < 5; i++) begin
            start_stream(vecs[i].start_pc, vecs[i].limit, vecs[i].lat, vecs[i].redir_at,
                         vecs[i].redir_pc, vecs[i].err_pc, vecs[i].gap);
            drain(vecs[i].exp_n);
            $display("vector %0d start_pc=%h delivered=%0d", i, vecs[i].start_pc, delivered);
        end

        // Decode stalled: credit runs out after two fetches, then resumes once decode drains.
        id_ready_en = 1'b0;
        start_stream(32'h0000_0040, 100, 1, 0, 32'h0, NO_ERR, 1'b0);
        repeat (6) cycle();
        check("stall_accepts", 32'(accepted), 32'd2);
        check("stall_req_valid", 32'(imem_req_valid_o), 32'd0);
        id_ready_en = 1'b1;
        id_ready_i  = 1'b1;
        limit       = accepted + 3;
        drain(5);
        $display("credit stall delivered=%0d", delivered);

        // Asynchronous reset between clock edges with one entry buffered and one in flight.
        id_ready_en = 1'b0;
        start_stream(32'h0000_0500, 2, 1, 0, 32'h0, NO_ERR, 1'b0);
        cycle();
        cycle();
        check("pre_rst_id_valid", 32'(id_valid_o), 32'd1);
        #2;
        rst              = 1'b0;
        imem_rsp_valid_i = 1'b0;
        #1;
        check("async_rst_id_valid", 32'(id_valid_o), 32'd0);
        check("async_rst_req_valid", 32'(imem_req_valid_o), 32'd0);
        check("async_rst_pc_en", 32'(pc_en_o), 32'd0);
        mq.delete();
        exp_q.delete();
        inflight_m  = 0;
        ibuf_m      = 0;
        drop_m      = 0;
        id_ready_en = 1'b1;
        repeat (2) cycle();
        rst = 1'b1;
        start_stream(32'h0000_0000, 3, 1, 0, 32'h0, NO_ERR, 1'b0);
        drain(3);
        $display("post reset restart delivered=%0d", delivered);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
